// File: rtl/ram_pkg.sv
// Shared constants and FSM state encoding for the synchronous scratch RAM.
package ram_pkg;

  localparam logic OP_READ  = 1'b0;
  localparam logic OP_WRITE = 1'b1;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_e;

endpackage

// File: rtl/ram_sync_tri_state_buffer.sv
// Tri-state driver: passes the input through when enabled, otherwise releases the bus.
module tri_state_buffer #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] in,
  input  logic             en,
  output wire  [WIDTH-1:0] out
);

  assign out = en ? in : {WIDTH{1'bz}};

endmodule

// File: rtl/ram_sync.sv
// WIDTH x DEPTH register-file RAM with a single shared port, one-cycle registered
// read onto a tri-state bus, and a hardware clear sweep run by a two-state FSM.
module ram_sync
  import ram_pkg::*;
#(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 8,
  localparam int ADR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sel,
  input  logic             op,
  input  logic [ADR_W-1:0] adr,
  input  logic [WIDTH-1:0] inp,
  input  logic             clr,
  output wire  [WIDTH-1:0] outp,
  output logic             valid,
  output logic             busy
);

  state_e           state_q, state_d;
  logic [ADR_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] rdata_q, rdata_d;
  logic             valid_q, valid_d;
  logic             busy_q, busy_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];

  // Next-state logic: clear has priority over requests; out-of-range addresses
  // match no word, so writes drop and reads return zero.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    valid_d = 1'b0;
    mem_d   = mem_q;
    case (state_q)
      IDLE: begin
        if (clr) begin
          state_d = CLEAR;
          cnt_d   = '0;
        end else if (sel) begin
          if (op == OP_WRITE) begin
            for (int i = 0; i < DEPTH; i++) begin
              if (adr == ADR_W'(i)) mem_d[i] = inp;
            end
          end else begin
            rdata_d = '0;
            for (int i = 0; i < DEPTH; i++) begin
              if (adr == ADR_W'(i)) rdata_d = mem_q[i];
            end
            valid_d = 1'b1;
          end
        end
      end
      CLEAR: begin
        for (int i = 0; i < DEPTH; i++) begin
          if (cnt_q == ADR_W'(i)) mem_d[i] = '0;
        end
        if (cnt_q == ADR_W'(DEPTH - 1)) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + ADR_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == CLEAR);
  end

  // State, memory and output registers; reset zeroes everything immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rdata_q <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      mem_q   <= mem_d;
    end
  end

  tri_state_buffer #(.WIDTH(WIDTH)) u_obuf (
    .in  (rdata_q),
    .en  (valid_q),
    .out (outp)
  );

  assign valid = valid_q;
  assign busy  = busy_q;

endmodule

// File: tb/tb_ram_sync.sv
// Self-checking bench for ram_sync: an 8x8 instance and a 16x5 instance on
// pulled-up buses, with a read-data scoreboard queue fed at request time.
module tb_ram_sync;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  logic        sel_a, op_a, clr_a;
  logic [2:0]  adr_a;
  logic [7:0]  inp_a;
  wire  [7:0]  bus_a;
  logic        valid_a, busy_a;

  logic        sel_b, op_b, clr_b;
  logic [2:0]  adr_b;
  logic [15:0] inp_b;
  wire  [15:0] bus_b;
  logic        valid_b, busy_b;

  pullup pu_a (bus_a);
  pullup pu_b (bus_b);

  ram_sync #(.WIDTH(8), .DEPTH(8)) dut_a (
    .clk(clk), .rst_n(rst_n), .sel(sel_a), .op(op_a), .adr(adr_a), .inp(inp_a),
    .clr(clr_a), .outp(bus_a), .valid(valid_a), .busy(busy_a)
  );

  ram_sync #(.WIDTH(16), .DEPTH(5)) dut_b (
    .clk(clk), .rst_n(rst_n), .sel(sel_b), .op(op_b), .adr(adr_b), .inp(inp_b),
    .clr(clr_b), .outp(bus_b), .valid(valid_b), .busy(busy_b)
  );

  int n_checks = 0;
  int n_fail   = 0;
  logic [15:0] exp_q [$];
  logic [15:0] exp;
  logic [7:0]  model_a [8];
  logic [15:0] model_b [5];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all();
    sel_a = 1'b0; op_a = 1'b0; clr_a = 1'b0;
    sel_b = 1'b0; op_b = 1'b0; clr_b = 1'b0;
  endtask

  task automatic zero_models();
    for (int i = 0; i < 8; i++) model_a[i] = 8'h00;
    for (int i = 0; i < 5; i++) model_b[i] = 16'h0000;
  endtask

  task automatic wr_a(input logic [2:0] a, input logic [7:0] d);
    sel_a = 1'b1; op_a = 1'b1; adr_a = a; inp_a = d;
    model_a[a] = d;
    step();
  endtask

  task automatic rd_a(input logic [2:0] a);
    sel_a = 1'b1; op_a = 1'b0; adr_a = a;
    exp_q.push_back({8'h00, model_a[a]});
    step();
  endtask

  task automatic test_reset();
    idle_all();
    rst_n = 1'b0;
    #3;
    n_checks++;
    if (valid_a !== 1'b0 || busy_a !== 1'b0 || bus_a !== 8'hFF) begin
      n_fail++;
      $display("FAIL reset_a: valid=%b busy=%b bus=%h, want valid=0 busy=0 bus=ff", valid_a, busy_a, bus_a);
    end
    n_checks++;
    if (valid_b !== 1'b0 || busy_b !== 1'b0 || bus_b !== 16'hFFFF) begin
      n_fail++;
      $display("FAIL reset_b: valid=%b busy=%b bus=%h, want valid=0 busy=0 bus=ffff", valid_b, busy_b, bus_b);
    end
    step();
    @(negedge clk);
    rst_n = 1'b1;
    zero_models();
    step();
  endtask

  task automatic test_write_read();
    logic [7:0] vals [8];
    vals = '{8'h00, 8'hAA, 8'hCC, 8'hF0, 8'h0F, 8'h33, 8'h55, 8'h99};
    for (int i = 1; i < 8; i++) wr_a(3'(i), vals[i]);
    for (int i = 0; i < 8; i++) begin
      rd_a(3'(i));
      exp = exp_q.pop_front();
      n_checks++;
      if (valid_a !== 1'b1 || bus_a !== exp[7:0] || exp[7:0] !== vals[i]) begin
        n_fail++;
        $display("FAIL wr_rd adr=%0d: valid=%b data=%h, want valid=1 data=%h", i, valid_a, bus_a, vals[i]);
      end
      sel_a = 1'b0;
      step();
      n_checks++;
      if (valid_a !== 1'b0 || bus_a !== 8'hFF) begin
        n_fail++;
        $display("FAIL between_reads adr=%0d: valid=%b bus=%h, want valid=0 bus=ff", i, valid_a, bus_a);
      end
    end
  endtask

  task automatic test_back_to_back();
    wr_a(3'd1, 8'hAA);
    for (int k = 1; k <= 3; k++) begin
      rd_a(3'(k));
      exp = exp_q.pop_front();
      n_checks++;
      if (valid_a !== 1'b1 || bus_a !== exp[7:0]) begin
        n_fail++;
        $display("FAIL b2b adr=%0d: valid=%b data=%h, want valid=1 data=%h", k, valid_a, bus_a, exp[7:0]);
      end
    end
    sel_a = 1'b0;
    step();
    n_checks++;
    if (valid_a !== 1'b0 || bus_a !== 8'hFF) begin
      n_fail++;
      $display("FAIL b2b_end: valid=%b bus=%h, want valid=0 bus=ff", valid_a, bus_a);
    end
  endtask

  task automatic test_clear();
    for (int i = 0; i < 8; i++) wr_a(3'(i), 8'hA0 + 8'(i));
    clr_a = 1'b1; sel_a = 1'b1; op_a = 1'b0; adr_a = 3'd2;
    step();
    clr_a = 1'b0;
    n_checks++;
    if (valid_a !== 1'b0 || busy_a !== 1'b1 || bus_a !== 8'hFF) begin
      n_fail++;
      $display("FAIL clr_start: valid=%b busy=%b bus=%h, want valid=0 busy=1 bus=ff", valid_a, busy_a, bus_a);
    end
    for (int k = 1; k <= 8; k++) begin
      sel_a = 1'b1; op_a = 1'b1; adr_a = 3'(k % 8); inp_a = 8'h77;
      step();
      n_checks++;
      if (busy_a !== (k < 8)) begin
        n_fail++;
        $display("FAIL clr_busy edge+%0d: busy=%b, want %b", k, busy_a, (k < 8));
      end
    end
    sel_a = 1'b0;
    zero_models();
    for (int i = 0; i < 8; i++) begin
      rd_a(3'(i));
      exp = exp_q.pop_front();
      n_checks++;
      if (valid_a !== 1'b1 || bus_a !== exp[7:0]) begin
        n_fail++;
        $display("FAIL clr_rd adr=%0d: valid=%b data=%h, want valid=1 data=%h", i, valid_a, bus_a, exp[7:0]);
      end
    end
    sel_a = 1'b0;
    step();
  endtask

  task automatic test_reset_mid();
    wr_a(3'd3, 8'h55);
    rd_a(3'd3);
    exp = exp_q.pop_front();
    n_checks++;
    if (valid_a !== 1'b1 || bus_a !== exp[7:0]) begin
      n_fail++;
      $display("FAIL pre_rst_rd: valid=%b data=%h, want valid=1 data=%h", valid_a, bus_a, exp[7:0]);
    end
    idle_all();
    #1 rst_n = 1'b0;
    #1;
    n_checks++;
    if (valid_a !== 1'b0 || busy_a !== 1'b0 || bus_a !== 8'hFF) begin
      n_fail++;
      $display("FAIL rst_mid_read: valid=%b busy=%b bus=%h, want valid=0 busy=0 bus=ff", valid_a, busy_a, bus_a);
    end
    @(negedge clk);
    rst_n = 1'b1;
    zero_models();
    wr_a(3'd4, 8'h66);
    wr_a(3'd6, 8'h12);
    sel_a = 1'b0; clr_a = 1'b1;
    step();
    clr_a = 1'b0;
    step();
    step();
    n_checks++;
    if (busy_a !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_sweep_busy: busy=%b, want 1", busy_a);
    end
    #1 rst_n = 1'b0;
    #1;
    n_checks++;
    if (valid_a !== 1'b0 || busy_a !== 1'b0 || bus_a !== 8'hFF) begin
      n_fail++;
      $display("FAIL rst_mid_sweep: valid=%b busy=%b bus=%h, want valid=0 busy=0 bus=ff", valid_a, busy_a, bus_a);
    end
    @(negedge clk);
    rst_n = 1'b1;
    zero_models();
    step();
    n_checks++;
    if (busy_a !== 1'b0) begin
      n_fail++;
      $display("FAIL post_rst_busy: busy=%b, want 0", busy_a);
    end
    for (int i = 0; i < 8; i++) begin
      rd_a(3'(i));
      exp = exp_q.pop_front();
      n_checks++;
      if (valid_a !== 1'b1 || bus_a !== 8'h00 || exp[7:0] !== 8'h00) begin
        n_fail++;
        $display("FAIL post_rst_rd adr=%0d: valid=%b data=%h, want valid=1 data=00", i, valid_a, bus_a);
      end
    end
    sel_a = 1'b0;
    step();
  endtask

  task automatic test_wide_oob();
    logic [2:0] rd_list [6];
    rd_list = '{3'd4, 3'd6, 3'd0, 3'd1, 3'd2, 3'd7};
    sel_b = 1'b1; op_b = 1'b1; adr_b = 3'd4; inp_b = 16'hBEEF;
    model_b[4] = 16'hBEEF;
    step();
    adr_b = 3'd6; inp_b = 16'h1234;
    step();
    adr_b = 3'd5; inp_b = 16'h5678;
    step();
    for (int i = 0; i < 6; i++) begin
      sel_b = 1'b1; op_b = 1'b0; adr_b = rd_list[i];
      exp_q.push_back((rd_list[i] < 3'd5) ? model_b[rd_list[i]] : 16'h0000);
      step();
      exp = exp_q.pop_front();
      n_checks++;
      if (valid_b !== 1'b1 || bus_b !== exp) begin
        n_fail++;
        $display("FAIL wide_rd adr=%0d: valid=%b data=%h, want valid=1 data=%h", rd_list[i], valid_b, bus_b, exp);
      end
    end
    sel_b = 1'b0;
    step();
    n_checks++;
    if (valid_b !== 1'b0 || bus_b !== 16'hFFFF) begin
      n_fail++;
      $display("FAIL wide_idle: valid=%b bus=%h, want valid=0 bus=ffff", valid_b, bus_b);
    end
  endtask

  task automatic test_idle();
    idle_all();
    for (int i = 0; i < 20; i++) begin
      step();
      n_checks++;
      if (valid_a !== 1'b0 || bus_a !== 8'hFF) begin
        n_fail++;
        $display("FAIL idle cycle=%0d: valid=%b bus=%h, want valid=0 bus=ff", i, valid_a, bus_a);
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    idle_all();
    adr_a = '0; inp_a = '0; adr_b = '0; inp_b = '0;
    zero_models();
    test_reset();
    test_write_read();
    test_back_to_back();
    test_clear();
    test_reset_mid();
    test_wide_oob();
    test_idle();
    if (exp_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL scoreboard: %0d reads left unchecked, want 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ram_sync.md
# ram_sync

Parametrised, clocked successor to the 8x8 asynchronous RAM: a WIDTH x DEPTH register-file memory with one shared read/write port and a registered tri-state output. It adds asynchronous active-low reset, a fixed one-cycle read latency with a `valid` strobe, and a hardware clear sweep driven by a small FSM. It sits between the bus controller and any block that needs small scratch storage on a shared tri-state data bus.

## Interface

Parameters:
- `WIDTH`, 8, data word width in bits (≥1)
- `DEPTH`, 8, number of words (≥2; need not be a power of two)
- `ADR_W`, `$clog2(DEPTH)`, address width; derived, not overridden

Ports:
- `clk`  in  1  clock; all state changes on rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `sel`  in  1  port select; a request is taken only when 1
- `op`  in  1  1 = write, 0 = read
- `adr`  in  ADR_W  word address
- `inp`  in  WIDTH  write data
- `clr`  in  1  start clear sweep (single-cycle pulse)
- `outp`  out  WIDTH  read data, tri-state; high-Z when not valid
- `valid`  out  1  `outp` is driven with read data this cycle
- `busy`  out  1  clear sweep in progress; requests ignored

## Operation

- FSM states: IDLE, CLEAR.
- IDLE, `clr`=1: go to CLEAR; clear counter = 0; request on `sel` in the same cycle is dropped (`clr` has priority).
- IDLE, `sel`=1, `op`=1: `mem[adr] <= inp` at the edge.
- IDLE, `sel`=1, `op`=0: `mem[adr]` captured into the output register; `valid`=1 for exactly the next cycle.
- IDLE, `sel`=0: no access; `valid` drops after any pending read cycle.
- CLEAR: write 0 to `mem[cnt]`, `cnt++` each cycle; after writing `DEPTH-1`, return to IDLE. `busy`=1 throughout CLEAR. `sel`, `clr` ignored.
- Out-of-range address (`adr` ≥ DEPTH): write ignored; read returns all-zero with `valid`=1.
- Back-to-back reads with `sel` held high: a new word on every cycle; `valid` stays 1.
- Write followed by read of the same address on the next cycle returns the new data.

## Timing

- Reset (`rst_n`=0, asynchronous): all `mem` words = 0, state = IDLE, counter = 0, output register = 0, `valid`=0, `busy`=0, `outp` = high-Z. Takes effect immediately. Release is synchronous to the next `clk` edge.
- Reset mid-sweep: sweep aborted; memory is zero anyway; IDLE after release.
- Write latency: 0. Data is visible to a read issued in the following cycle.
- Read latency: 1. Request at edge N gives `valid`/`outp` during cycle N→N+1.
- `outp` is driven only while `valid`=1, otherwise high-Z. No other driver state exists.
- Clear: pulse at edge N gives `busy`=1 from N through N+DEPTH. Accepts requests again at edge N+DEPTH+1.
- A read issued at the edge where `clr` is seen is dropped, and `valid` stays 0.

## Structure

- Shared package `ram_pkg`: `OP_READ`=1'b0 and `OP_WRITE`=1'b1 constants, plus the FSM state enum (IDLE, CLEAR).
- Sub-module `tri_state_buffer` (parameter WIDTH; ports `in`, `en`, `out`) drives `outp` from the output register with `en`=`valid`.
- The memory array, FSM, clear counter and output register stay in `ram_sync`.

## Test plan

- Reset, then write AA@1, CC@2, F0@3, 0F@4, 33@5, 55@6, 99@7, then read each back. Each read gives the matching value with `valid`=1 one cycle later, and `outp` is Z between reads.
- Write AA@1, then read 1 on the very next cycle: `outp`=AA. Hold `sel`=1 while reading 1,2,3 back-to-back: AA, CC, F0 on consecutive cycles, `valid` continuously 1.
- Fill all words, pulse `clr` together with `sel`=1 read: read dropped, `busy`=1 for DEPTH=8 cycles, and writes issued during `busy` are ignored. Afterwards every address reads 00.
- Assert `rst_n`=0 mid-sweep and mid-read: `outp` goes Z and `valid`=`busy`=0 immediately. All words read 00 after release.
- Use WIDTH=16, DEPTH=5: write BEEF@4 reads back BEEF. Write to `adr`=6 is ignored, and a read of 6 returns 0000 with `valid`=1.
- With `sel`=0 for 20 cycles, `outp` stays high-Z (checked against a pull-up on the bench bus) and `valid` stays 0.
